// File: rtl/tmds_encoder.sv
// DVI TMDS 8b/10b encoder for one colour channel: transition minimisation plus
// running-disparity DC balancing, with control-period symbols when de is low.
module tmds_encoder (
  input  logic       clk25,
  input  logic       reset,
  input  logic       de,
  input  logic [7:0] data,
  input  logic [1:0] ctrl,
  output logic [9:0] symbol,
  output logic [5:0] disparity
);

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // XOR or XNOR chain, whichever yields fewer transitions; bit 8 flags XOR.
  function automatic logic [8:0] minimise(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = popcount8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && (d[0] == 1'b0));
    q        = 9'd0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) begin
      if (use_xnor) begin
        q[i] = ~(q[i-1] ^ d[i]);
      end else begin
        q[i] = q[i-1] ^ d[i];
      end
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

  logic              in_de_q, in_de_d;
  logic [7:0]        in_data_q, in_data_d;
  logic [1:0]        in_ctrl_q, in_ctrl_d;
  logic [8:0]        qm_q, qm_d;
  logic [3:0]        n1q_q, n1q_d;
  logic              de1_q, de1_d;
  logic [1:0]        ctrl1_q, ctrl1_d;
  logic [9:0]        symbol_q, symbol_d;
  logic signed [5:0] cnt_q, cnt_d;
  logic signed [5:0] n1s, n0s, diff;

  // Input capture and transition minimisation; data is zeroed in blanking so
  // undriven pixel values never reach the encoder state.
  always_comb begin
    in_de_d   = de;
    in_data_d = de ? data : 8'h00;
    in_ctrl_d = ctrl;
    qm_d      = minimise(in_data_q);
    n1q_d     = popcount8(qm_d[7:0]);
    de1_d     = in_de_q;
    ctrl1_d   = in_ctrl_q;
  end

  // DC balancing against the running disparity, or control symbol selection.
  always_comb begin
    n1s      = $signed({2'b00, n1q_q});
    n0s      = 6'sd8 - n1s;
    diff     = n1s - n0s;
    symbol_d = CTRL_00;
    cnt_d    = 6'sd0;
    if (!de1_q) begin
      cnt_d = 6'sd0;
      case (ctrl1_q)
        2'b00:   symbol_d = CTRL_00;
        2'b01:   symbol_d = CTRL_01;
        2'b10:   symbol_d = CTRL_10;
        default: symbol_d = CTRL_11;
      endcase
    end else if ((cnt_q == 6'sd0) || (diff == 6'sd0)) begin
      symbol_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
      cnt_d    = qm_q[8] ? (cnt_q + diff) : (cnt_q - diff);
    end else if (((cnt_q > 6'sd0) && (diff > 6'sd0)) ||
                 ((cnt_q < 6'sd0) && (diff < 6'sd0))) begin
      symbol_d = {1'b1, qm_q[8], ~qm_q[7:0]};
      cnt_d    = cnt_q - diff + (qm_q[8] ? 6'sd2 : 6'sd0);
    end else begin
      symbol_d = {1'b0, qm_q[8], qm_q[7:0]};
      cnt_d    = cnt_q + diff - (qm_q[8] ? 6'sd0 : 6'sd2);
    end
  end

  // Pipeline registers; reset discards anything in flight.
  always_ff @(posedge clk25) begin
    if (reset) begin
      in_de_q   <= 1'b0;
      in_data_q <= 8'h00;
      in_ctrl_q <= 2'b00;
      qm_q      <= 9'd0;
      n1q_q     <= 4'd0;
      de1_q     <= 1'b0;
      ctrl1_q   <= 2'b00;
      symbol_q  <= CTRL_00;
      cnt_q     <= 6'sd0;
    end else begin
      in_de_q   <= in_de_d;
      in_data_q <= in_data_d;
      in_ctrl_q <= in_ctrl_d;
      qm_q      <= qm_d;
      n1q_q     <= n1q_d;
      de1_q     <= de1_d;
      ctrl1_q   <= ctrl1_d;
      symbol_q  <= symbol_d;
      cnt_q     <= cnt_d;
    end
  end

  assign symbol    = symbol_q;
  assign disparity = cnt_q;

endmodule
